// File: rtl/fetch_redirect_ctrl_pkg.sv
// rtl/fetch_redirect_ctrl_pkg.sv - shared front-end redirect constants
// Sequencer states and redirect_cause encodings used across the fetch redirect path.
package fetch_redirect_ctrl_pkg;

   localparam int ADDR_W_DEF = 32;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_ISSUE = 2'd2;

   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_EXCP    = 2'd1;
   localparam logic [1:0] CAUSE_MISPRED = 2'd2;
   localparam logic [1:0] CAUSE_BPU     = 2'd3;

endpackage

// File: rtl/fetch_redirect_ctrl_mispred_check.sv
// rtl/fetch_redirect_ctrl_mispred_check.sv - per-slot mispredict detect and correct target
// Purely combinational; the top instantiates one per EX issue slot.
module mispred_check
   import fetch_redirect_ctrl_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              valid_i,
   input  logic              is_bj_i,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              pred_taken_i,
   input  logic [ADDR_W-1:0] pred_addr_i,
   input  logic              real_taken_i,
   input  logic [ADDR_W-1:0] real_addr_i,
   output logic              mispred_o,
   output logic [ADDR_W-1:0] target_o
);

   logic dir_wrong;
   logic addr_wrong;

   assign dir_wrong  = (real_taken_i != pred_taken_i);
   // A target mismatch only matters when the branch was actually taken.
   assign addr_wrong = real_taken_i & (real_addr_i != pred_addr_i);
   assign mispred_o  = valid_i & is_bj_i & (dir_wrong | addr_wrong);
   assign target_o   = real_taken_i ? real_addr_i : (pc_i + ADDR_W'(4));

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// rtl/fetch_redirect_ctrl.sv - front-end redirect arbiter and flush/drain/issue sequencer
// Optional statistics counters are built when FETCH_REDIRECT_STAT_EN is defined.
module fetch_redirect_ctrl
   import fetch_redirect_ctrl_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int CNT_W  = 32
) (
   input  logic                   cpu_clk,
   input  logic                   cpu_rst,
   input  logic                   excp_valid,
   input  logic [ADDR_W-1:0]      excp_pc,
   input  logic [1:0]             ex_valid,
   input  logic [1:0]             ex_is_bj,
   input  logic [1:0][ADDR_W-1:0] ex_pc,
   input  logic [1:0]             ex_pred_taken,
   input  logic [1:0][ADDR_W-1:0] ex_pred_addr,
   input  logic [1:0]             ex_real_taken,
   input  logic [1:0][ADDR_W-1:0] ex_real_addr,
   input  logic                   bpu_pred_taken,
   input  logic [ADDR_W-1:0]      bpu_pred_addr,
   input  logic                   icache_busy,
   input  logic                   icache_resp_valid,
   output logic                   redirect_valid,
   output logic [ADDR_W-1:0]      redirect_pc,
   output logic                   pc_flush,
   output logic                   ibuf_flush,
   output logic                   icache_discard,
   output logic                   fetch_stall,
   output logic [1:0]             redirect_cause,
   output logic [1:0]             bpu_update_en
`ifdef FETCH_REDIRECT_STAT_EN
   ,output logic [CNT_W-1:0]      excp_cnt
   ,output logic [CNT_W-1:0]      mispred_cnt
   ,output logic [CNT_W-1:0]      bpu_redir_cnt
`endif
);

   logic [1:0]              state_q, state_d;
   logic [ADDR_W-1:0]       target_q, target_d;
   logic [ADDR_W-1:0]       last_pc_q, last_pc_d;
   logic [1:0]              cause_q, cause_d;
   logic [1:0]              upd_q, upd_d;
   logic                    flush_q, flush_d;
   logic                    bpu_fire_q, bpu_fire_d;

   logic [1:0]              mis;
   logic [1:0][ADDR_W-1:0]  tgt;
   logic                    in_idle;
   logic                    acc_excp;
   logic                    acc_mis;
   logic                    acc_bpu;
   logic                    issue_fire;

   for (genvar s = 0; s < 2; s++) begin : g_chk
      mispred_check #(.ADDR_W(ADDR_W)) u_chk (
         .valid_i      (ex_valid[s]),
         .is_bj_i      (ex_is_bj[s]),
         .pc_i         (ex_pc[s]),
         .pred_taken_i (ex_pred_taken[s]),
         .pred_addr_i  (ex_pred_addr[s]),
         .real_taken_i (ex_real_taken[s]),
         .real_addr_i  (ex_real_addr[s]),
         .mispred_o    (mis[s]),
         .target_o     (tgt[s])
      );
   end

   assign in_idle  = (state_q == ST_IDLE);
   assign acc_excp = excp_valid;
   // Mispredict and BPU requests outside IDLE belong to the wrong path.
   assign acc_mis  = in_idle & (|mis) & ~excp_valid;
   assign acc_bpu  = in_idle & bpu_pred_taken & ~excp_valid & ~(|mis);
   // The first ISSUE cycle carries the flush; the redirect goes out on the next one.
   assign issue_fire = (state_q == ST_ISSUE) & ~flush_q & ~excp_valid;

   always_comb begin
      state_d    = state_q;
      target_d   = target_q;
      last_pc_d  = last_pc_q;
      cause_d    = cause_q;
      upd_d      = 2'b00;
      flush_d    = 1'b0;
      bpu_fire_d = 1'b0;

      case (state_q)
         ST_DRAIN: if (icache_resp_valid) state_d = ST_ISSUE;
         ST_ISSUE: if (!flush_q) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      if (issue_fire) last_pc_d = target_q;

      if (acc_excp) begin
         target_d = excp_pc;
         cause_d  = CAUSE_EXCP;
         flush_d  = 1'b1;
         state_d  = icache_busy ? ST_DRAIN : ST_ISSUE;
      end else if (acc_mis) begin
         target_d = mis[0] ? tgt[0] : tgt[1];
         cause_d  = CAUSE_MISPRED;
         flush_d  = 1'b1;
         upd_d    = mis[0] ? 2'b01 : 2'b10;
         state_d  = icache_busy ? ST_DRAIN : ST_ISSUE;
      end else if (acc_bpu) begin
         last_pc_d  = bpu_pred_addr;
         cause_d    = CAUSE_BPU;
         bpu_fire_d = 1'b1;
      end
   end

   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         state_q    <= ST_IDLE;
         target_q   <= '0;
         last_pc_q  <= '0;
         cause_q    <= CAUSE_NONE;
         upd_q      <= 2'b00;
         flush_q    <= 1'b0;
         bpu_fire_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         target_q   <= target_d;
         last_pc_q  <= last_pc_d;
         cause_q    <= cause_d;
         upd_q      <= upd_d;
         flush_q    <= flush_d;
         bpu_fire_q <= bpu_fire_d;
      end
   end

   assign redirect_valid = bpu_fire_q | issue_fire;
   assign redirect_pc    = issue_fire ? target_q : last_pc_q;
   assign pc_flush       = flush_q;
   assign ibuf_flush     = flush_q;
   assign icache_discard = (state_q == ST_DRAIN);
   assign fetch_stall    = (state_q == ST_DRAIN);
   assign redirect_cause = cause_q;
   assign bpu_update_en  = upd_q;

`ifdef FETCH_REDIRECT_STAT_EN
   logic [CNT_W-1:0] excp_cnt_q, mispred_cnt_q, bpu_redir_cnt_q;

   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         excp_cnt_q      <= '0;
         mispred_cnt_q   <= '0;
         bpu_redir_cnt_q <= '0;
      end else begin
         if (acc_excp && excp_cnt_q != '1)     excp_cnt_q      <= excp_cnt_q + 1'b1;
         if (acc_mis && mispred_cnt_q != '1)   mispred_cnt_q   <= mispred_cnt_q + 1'b1;
         if (acc_bpu && bpu_redir_cnt_q != '1) bpu_redir_cnt_q <= bpu_redir_cnt_q + 1'b1;
      end
   end

   assign excp_cnt      = excp_cnt_q;
   assign mispred_cnt   = mispred_cnt_q;
   assign bpu_redir_cnt = bpu_redir_cnt_q;
`else
   logic unused_cnt_w;
   assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb/tb_fetch_redirect_ctrl.sv - directed self-checking bench for fetch_redirect_ctrl
module tb_fetch_redirect_ctrl;

   logic             cpu_clk = 1'b0;
   logic             cpu_rst = 1'b1;
   logic             excp_valid;
   logic [31:0]      excp_pc;
   logic [1:0]       ex_valid, ex_is_bj, ex_pred_taken, ex_real_taken;
   logic [1:0][31:0] ex_pc, ex_pred_addr, ex_real_addr;
   logic             bpu_pred_taken;
   logic [31:0]      bpu_pred_addr;
   logic             icache_busy, icache_resp_valid;
   logic             redirect_valid;
   logic [31:0]      redirect_pc;
   logic             pc_flush, ibuf_flush, icache_discard, fetch_stall;
   logic [1:0]       redirect_cause, bpu_update_en;
`ifdef FETCH_REDIRECT_STAT_EN
   logic [31:0]      excp_cnt, mispred_cnt, bpu_redir_cnt;
`endif

   int tests = 0;
   int fails = 0;

   always #5 cpu_clk = ~cpu_clk;

   fetch_redirect_ctrl #(.ADDR_W(32), .CNT_W(32)) dut (
      .cpu_clk           (cpu_clk),
      .cpu_rst           (cpu_rst),
      .excp_valid        (excp_valid),
      .excp_pc           (excp_pc),
      .ex_valid          (ex_valid),
      .ex_is_bj          (ex_is_bj),
      .ex_pc             (ex_pc),
      .ex_pred_taken     (ex_pred_taken),
      .ex_pred_addr      (ex_pred_addr),
      .ex_real_taken     (ex_real_taken),
      .ex_real_addr      (ex_real_addr),
      .bpu_pred_taken    (bpu_pred_taken),
      .bpu_pred_addr     (bpu_pred_addr),
      .icache_busy       (icache_busy),
      .icache_resp_valid (icache_resp_valid),
      .redirect_valid    (redirect_valid),
      .redirect_pc       (redirect_pc),
      .pc_flush          (pc_flush),
      .ibuf_flush        (ibuf_flush),
      .icache_discard    (icache_discard),
      .fetch_stall       (fetch_stall),
      .redirect_cause    (redirect_cause),
      .bpu_update_en     (bpu_update_en)
`ifdef FETCH_REDIRECT_STAT_EN
      ,.excp_cnt         (excp_cnt)
      ,.mispred_cnt      (mispred_cnt)
      ,.bpu_redir_cnt    (bpu_redir_cnt)
`endif
   );

   typedef struct {
      logic        excp;
      logic [31:0] epc;
      logic [1:0]  val, bj, pt, rt;
      logic [31:0] pc0, pa0, ra0, pc1, pa1, ra1;
      logic        bpu;
      logic [31:0] bpc;
      logic        e1_flush;
      logic [1:0]  e1_cause, e1_upd;
      logic        e1_rv;
      logic [31:0] e1_pc;
      logic        e2_rv;
      logic [31:0] e2_pc;
   } vec_t;

   vec_t vecs[11];

   function automatic vec_t mk(
      input logic excp, input logic [31:0] epc,
      input logic [1:0] val, input logic [1:0] bj, input logic [1:0] pt, input logic [1:0] rt,
      input logic [31:0] pc0, input logic [31:0] pa0, input logic [31:0] ra0,
      input logic [31:0] pc1, input logic [31:0] pa1, input logic [31:0] ra1,
      input logic bpu, input logic [31:0] bpc,
      input logic e1_flush, input logic [1:0] e1_cause, input logic [1:0] e1_upd,
      input logic e1_rv, input logic [31:0] e1_pc,
      input logic e2_rv, input logic [31:0] e2_pc);
      vec_t v;
      v.excp = excp; v.epc = epc; v.val = val; v.bj = bj; v.pt = pt; v.rt = rt;
      v.pc0 = pc0; v.pa0 = pa0; v.ra0 = ra0; v.pc1 = pc1; v.pa1 = pa1; v.ra1 = ra1;
      v.bpu = bpu; v.bpc = bpc;
      v.e1_flush = e1_flush; v.e1_cause = e1_cause; v.e1_upd = e1_upd;
      v.e1_rv = e1_rv; v.e1_pc = e1_pc; v.e2_rv = e2_rv; v.e2_pc = e2_pc;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic clear_inputs();
      excp_valid = 0; excp_pc = 0;
      ex_valid = 0; ex_is_bj = 0; ex_pred_taken = 0; ex_real_taken = 0;
      ex_pc = '0; ex_pred_addr = '0; ex_real_addr = '0;
      bpu_pred_taken = 0; bpu_pred_addr = 0;
      icache_busy = 0; icache_resp_valid = 0;
   endtask

   task automatic drive_vec(input vec_t v, input logic busy);
      excp_valid = v.excp; excp_pc = v.epc;
      ex_valid = v.val; ex_is_bj = v.bj; ex_pred_taken = v.pt; ex_real_taken = v.rt;
      ex_pc[0] = v.pc0; ex_pred_addr[0] = v.pa0; ex_real_addr[0] = v.ra0;
      ex_pc[1] = v.pc1; ex_pred_addr[1] = v.pa1; ex_real_addr[1] = v.ra1;
      bpu_pred_taken = v.bpu; bpu_pred_addr = v.bpc;
      icache_busy = busy;
   endtask

   task automatic check_idle_outputs(input string nm);
      chk({nm, " redirect_valid"}, 32'(redirect_valid), 0);
      chk({nm, " redirect_pc"}, redirect_pc, 0);
      chk({nm, " pc_flush"}, 32'(pc_flush), 0);
      chk({nm, " ibuf_flush"}, 32'(ibuf_flush), 0);
      chk({nm, " icache_discard"}, 32'(icache_discard), 0);
      chk({nm, " fetch_stall"}, 32'(fetch_stall), 0);
      chk({nm, " redirect_cause"}, 32'(redirect_cause), 0);
      chk({nm, " bpu_update_en"}, 32'(bpu_update_en), 0);
   endtask

   initial begin
      vec_t base;
      clear_inputs();

      //        excp epc          val    bj     pt     rt     pc0          pa0          ra0          pc1          pa1          ra1          bpu bpc          fl cause upd   rv1 pc1          rv2 pc2
      vecs[0]  = mk(0, 0,           2'b01, 2'b01, 2'b01, 2'b00, 32'h1c000040, 32'h1c000100, 0,           0,           0,           0,           0, 0,           1, 2'd2, 2'b01, 0, 0,           1, 32'h1c000044);
      vecs[1]  = mk(0, 0,           2'b01, 2'b01, 2'b01, 2'b01, 32'h1c000040, 32'h1c000100, 32'h1c000180, 0,          0,           0,           0, 0,           1, 2'd2, 2'b01, 0, 0,           1, 32'h1c000180);
      vecs[2]  = mk(0, 0,           2'b11, 2'b11, 2'b00, 2'b10, 32'h1c000040, 0,           0,           32'h1c000048, 0,           32'h1c000200, 0, 0,           1, 2'd2, 2'b10, 0, 0,           1, 32'h1c000200);
      vecs[3]  = mk(0, 0,           2'b11, 2'b11, 2'b01, 2'b10, 32'h1c000040, 32'h1c000100, 0,           32'h1c000048, 0,           32'h1c000200, 0, 0,           1, 2'd2, 2'b01, 0, 0,           1, 32'h1c000044);
      vecs[4]  = mk(1, 32'h1c008000, 2'b11, 2'b11, 2'b01, 2'b10, 32'h1c000040, 32'h1c000100, 0,          32'h1c000048, 0,           32'h1c000200, 0, 0,           1, 2'd1, 2'b00, 0, 0,           1, 32'h1c008000);
      vecs[5]  = mk(0, 0,           2'b00, 2'b00, 2'b00, 2'b00, 0,           0,           0,           0,           0,           0,           1, 32'h1c000300, 0, 2'd3, 2'b00, 1, 32'h1c000300, 0, 0);
      vecs[6]  = mk(0, 0,           2'b01, 2'b01, 2'b01, 2'b00, 32'h1c000040, 32'h1c000100, 0,           0,           0,           0,           1, 32'h1c000300, 1, 2'd2, 2'b01, 0, 0,           1, 32'h1c000044);
      vecs[7]  = mk(0, 0,           2'b01, 2'b00, 2'b01, 2'b00, 32'h1c000040, 32'h1c000100, 0,           0,           0,           0,           1, 32'h1c000400, 0, 2'd3, 2'b00, 1, 32'h1c000400, 0, 0);
      vecs[8]  = mk(0, 0,           2'b00, 2'b11, 2'b00, 2'b11, 32'h1c000040, 0,           32'h1c000700, 32'h1c000048, 0,           32'h1c000800, 0, 0,           0, 2'd3, 2'b00, 0, 0,           0, 0);
      vecs[9]  = mk(0, 0,           2'b11, 2'b11, 2'b11, 2'b11, 32'h1c000040, 32'h1c000500, 32'h1c000500, 32'h1c000048, 32'h1c000600, 32'h1c000600, 0, 0,      0, 2'd3, 2'b00, 0, 0,           0, 0);
      vecs[10] = mk(0, 0,           2'b01, 2'b01, 2'b01, 2'b00, 32'hfffffffc, 32'h1c000100, 0,           0,           0,           0,           0, 0,           1, 2'd2, 2'b01, 0, 0,           1, 32'h00000000);

      // Reset state
      repeat (2) @(negedge cpu_clk);
      check_idle_outputs("in_reset");
      cpu_rst = 0;
      @(negedge cpu_clk);
      check_idle_outputs("after_reset");

      // Table: single-cycle events from IDLE with no icache read outstanding
      for (int i = 0; i < 11; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         drive_vec(vecs[i], 1'b0);
         @(negedge cpu_clk);
         clear_inputs();
         chk({tag, " T1 pc_flush"}, 32'(pc_flush), 32'(vecs[i].e1_flush));
         chk({tag, " T1 ibuf_flush"}, 32'(ibuf_flush), 32'(vecs[i].e1_flush));
         chk({tag, " T1 cause"}, 32'(redirect_cause), 32'(vecs[i].e1_cause));
         chk({tag, " T1 bpu_update_en"}, 32'(bpu_update_en), 32'(vecs[i].e1_upd));
         chk({tag, " T1 redirect_valid"}, 32'(redirect_valid), 32'(vecs[i].e1_rv));
         chk({tag, " T1 fetch_stall"}, 32'(fetch_stall), 0);
         if (vecs[i].e1_rv) chk({tag, " T1 redirect_pc"}, redirect_pc, vecs[i].e1_pc);
         @(negedge cpu_clk);
         chk({tag, " T2 redirect_valid"}, 32'(redirect_valid), 32'(vecs[i].e2_rv));
         chk({tag, " T2 pc_flush"}, 32'(pc_flush), 0);
         chk({tag, " T2 bpu_update_en"}, 32'(bpu_update_en), 0);
         if (vecs[i].e2_rv) chk({tag, " T2 redirect_pc"}, redirect_pc, vecs[i].e2_pc);
         repeat (2) @(negedge cpu_clk);
         chk({tag, " idle redirect_valid"}, 32'(redirect_valid), 0);
      end

      base = vecs[0];

      // Drain: busy at the event, response arrives at T+4
      drive_vec(base, 1'b1);
      for (int t = 1; t <= 4; t++) begin
         @(negedge cpu_clk);
         if (t == 1) begin
            ex_valid = 0; ex_is_bj = 0;
            chk("drain T1 pc_flush", 32'(pc_flush), 1);
         end
         chk($sformatf("drain T%0d fetch_stall", t), 32'(fetch_stall), 1);
         chk($sformatf("drain T%0d icache_discard", t), 32'(icache_discard), 1);
         chk($sformatf("drain T%0d redirect_valid", t), 32'(redirect_valid), 0);
      end
      icache_resp_valid = 1; icache_busy = 0;
      @(negedge cpu_clk);
      icache_resp_valid = 0;
      chk("drain T5 redirect_valid", 32'(redirect_valid), 1);
      chk("drain T5 redirect_pc", redirect_pc, 32'h1c000044);
      chk("drain T5 fetch_stall", 32'(fetch_stall), 0);
      @(negedge cpu_clk);
      chk("drain T6 redirect_valid", 32'(redirect_valid), 0);
      repeat (2) @(negedge cpu_clk);

      // Drain: wrong-path slot1 mispredict ignored, then exception re-flushes
      drive_vec(base, 1'b1);
      @(negedge cpu_clk);
      chk("reflush T1 pc_flush", 32'(pc_flush), 1);
      ex_valid = 2'b10; ex_is_bj = 2'b10; ex_pred_taken = 2'b00; ex_real_taken = 2'b10;
      ex_pc[1] = 32'h1c000048; ex_real_addr[1] = 32'h1c000200;
      @(negedge cpu_clk);
      chk("reflush T2 bpu_update_en", 32'(bpu_update_en), 0);
      chk("reflush T2 pc_flush", 32'(pc_flush), 0);
      chk("reflush T2 cause", 32'(redirect_cause), 2);
      chk("reflush T2 fetch_stall", 32'(fetch_stall), 1);
      ex_valid = 0; ex_is_bj = 0; ex_real_taken = 0;
      excp_valid = 1; excp_pc = 32'h1c008000;
      @(negedge cpu_clk);
      excp_valid = 0;
      chk("reflush T3 pc_flush", 32'(pc_flush), 1);
      chk("reflush T3 ibuf_flush", 32'(ibuf_flush), 1);
      chk("reflush T3 cause", 32'(redirect_cause), 1);
      chk("reflush T3 fetch_stall", 32'(fetch_stall), 1);
      chk("reflush T3 redirect_valid", 32'(redirect_valid), 0);
      icache_resp_valid = 1; icache_busy = 0;
      @(negedge cpu_clk);
      icache_resp_valid = 0;
      chk("reflush T4 redirect_valid", 32'(redirect_valid), 1);
      chk("reflush T4 redirect_pc", redirect_pc, 32'h1c008000);
      @(negedge cpu_clk);
      chk("reflush T5 redirect_valid", 32'(redirect_valid), 0);
      repeat (2) @(negedge cpu_clk);

      // Exception arriving in the issuing cycle suppresses that redirect
      drive_vec(base, 1'b0);
      @(negedge cpu_clk);
      clear_inputs();
      chk("issue_excp T1 pc_flush", 32'(pc_flush), 1);
      @(posedge cpu_clk);
      #1;
      excp_valid = 1; excp_pc = 32'h1c00a000;
      @(negedge cpu_clk);
      chk("issue_excp T2 redirect_valid", 32'(redirect_valid), 0);
      @(posedge cpu_clk);
      #1;
      excp_valid = 0;
      @(negedge cpu_clk);
      chk("issue_excp T3 pc_flush", 32'(pc_flush), 1);
      chk("issue_excp T3 cause", 32'(redirect_cause), 1);
      chk("issue_excp T3 redirect_valid", 32'(redirect_valid), 0);
      @(negedge cpu_clk);
      chk("issue_excp T4 redirect_valid", 32'(redirect_valid), 1);
      chk("issue_excp T4 redirect_pc", redirect_pc, 32'h1c00a000);
      repeat (2) @(negedge cpu_clk);

      // Reset asserted during DRAIN aborts the sequence
      drive_vec(base, 1'b1);
      @(negedge cpu_clk);
      ex_valid = 0; ex_is_bj = 0;
      @(negedge cpu_clk);
      chk("rst_drain pre fetch_stall", 32'(fetch_stall), 1);
      #1;
      cpu_rst = 1;
      #1;
      check_idle_outputs("rst_drain");
      @(negedge cpu_clk);
      cpu_rst = 0;
      icache_busy = 0; icache_resp_valid = 1;
      @(negedge cpu_clk);
      icache_resp_valid = 0;
      for (int t = 0; t < 4; t++) begin
         chk($sformatf("rst_drain post%0d redirect_valid", t), 32'(redirect_valid), 0);
         @(negedge cpu_clk);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
